// File: rtl/serial_par_multiplier_n.sv
// Serial-parallel unsigned multiplier.
// y is captured in parallel on start; x arrives LSB first under x_valid/x_ready.
// The product streams out LSB first on pbit and is presented as a held
// parallel word with a one-cycle done pulse when the last bit is produced.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; product holds the last completed result
// RUN   | consuming XW serial x bits, one per accepted handshake
// FLUSH | shifting the YW upper product bits out of hi
module serial_par_multiplier_n #(
  parameter int YW = 4,
  parameter int XW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [YW-1:0]    y,
  input  logic             x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             busy,
  output logic             pbit,
  output logic             pbit_valid,
  output logic [XW+YW-1:0] product,
  output logic             done
);

  localparam int PW   = XW + YW;
  localparam int CMAX = (XW > YW) ? XW : YW;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [YW-1:0]   y_reg;
  logic [YW-1:0]   hi;
  logic [PW-1:0]   res;
  logic [CW-1:0]   cnt;
  logic [YW:0]     sum;
  logic            run_last;
  logic            flush_last;

  // Partial-sum adder: one extra bit so the carry lands in the new hi MSB.
  always_comb begin
    sum = {1'b0, hi} + (x ? {1'b0, y_reg} : {(YW+1){1'b0}});
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    x_ready    = 1'b0;
    busy       = 1'b0;
    run_last   = (cnt == CW'(XW - 1));
    flush_last = (cnt == CW'(YW - 1));
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        x_ready = 1'b1;
        busy    = 1'b1;
        if (x_valid && run_last) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand capture, shift-add step, flush shift and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg      <= '0;
      hi         <= '0;
      res        <= '0;
      cnt        <= '0;
      pbit       <= 1'b0;
      pbit_valid <= 1'b0;
      product    <= '0;
      done       <= 1'b0;
    end else begin
      pbit_valid <= 1'b0;
      done       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            y_reg <= y;
            hi    <= '0;
            res   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (x_valid) begin
            pbit       <= sum[0];
            pbit_valid <= 1'b1;
            hi         <= sum[YW:1];
            res        <= {sum[0], res[PW-1:1]};
            cnt        <= run_last ? '0 : cnt + 1'b1;
          end
        end
        FLUSH: begin
          pbit       <= hi[0];
          pbit_valid <= 1'b1;
          hi         <= hi >> 1;
          res        <= {hi[0], res[PW-1:1]};
          cnt        <= cnt + 1'b1;
          if (flush_last) begin
            product <= {hi[0], res[PW-1:1]};
            done    <= 1'b1;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_par_multiplier_n.sv
// Directed bench for serial_par_multiplier_n with YW=4, XW=8.
module tb_serial_par_multiplier_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  y;
  logic        x;
  logic        x_valid;
  logic        x_ready;
  logic        busy;
  logic        pbit;
  logic        pbit_valid;
  logic [11:0] product;
  logic        done;

  int checks   = 0;
  int failures = 0;

  serial_par_multiplier_n #(.YW(4), .XW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y          (y),
    .x          (x),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .busy       (busy),
    .pbit       (pbit),
    .pbit_valid (pbit_valid),
    .product    (product),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after an edge: accept edge happens inside.
  task automatic start_op(input logic [3:0] yv);
    start = 1'b1;
    y     = yv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds xv LSB first until done (bounded), collecting the pbit stream.
  task automatic feed(input logic [7:0] xv, input bit toggle, input int pulse_at,
                      input logic [11:0] old_prod, output logic [11:0] stream,
                      output int nbits, output int done_cyc, output int first_v,
                      output int errs);
    int  bi;
    bit  vdrv, rdy, bz, exp_v;
    bi = 0; nbits = 0; done_cyc = -1; first_v = -1; errs = 0; stream = '0;
    for (int k = 0; k < 100; k++) begin
      vdrv    = toggle ? (k % 2 == 0) : 1'b1;
      x_valid = vdrv;
      x       = (bi < 8) ? xv[bi] : 1'b0;
      if (k == pulse_at) begin start = 1'b1; y = 4'h5; end
      rdy = x_ready;
      bz  = busy;
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy && vdrv) bi++;
      exp_v = bz && (!rdy || vdrv);
      if (pbit_valid !== exp_v) errs++;
      if (pbit_valid === 1'b1) begin
        if (first_v < 0) first_v = k + 1;
        if (nbits < 12) stream[nbits] = pbit;
        nbits++;
      end
      if (done === 1'b1) begin
        done_cyc = k + 1;
        break;
      end
      if (busy !== 1'b1) errs++;
      if (product !== old_prod) errs++;
    end
    x_valid = 1'b0;
  endtask

  logic [11:0] stream;
  int nbits, done_cyc, first_v, errs, dn;

  initial begin
    rst = 1'b1; start = 1'b0; y = '0; x = 1'b0; x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    busy,       0);
    chk("rst_xready",  x_ready,    0);
    chk("rst_pvalid",  pbit_valid, 0);
    chk("rst_pbit",    pbit,       0);
    chk("rst_product", product,    0);
    chk("rst_done",    done,       0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0xF * 0xFF, x_valid held high
    start_op(4'hF);
    chk("ef1_busy", busy, 1);
    feed(8'hFF, 1'b0, -1, 12'h000, stream, nbits, done_cyc, first_v, errs);
    chk("ef1_stream",  stream,   12'hEF1);
    chk("ef1_nbits",   nbits,    12);
    chk("ef1_first_v", first_v,  1);
    chk("ef1_done_at", done_cyc, 12);
    chk("ef1_product", product,  12'hEF1);
    chk("ef1_errs",    errs,     0);

    // back-to-back: start in the done cycle
    chk("b2b_idle_in_done", busy, 0);
    start_op(4'h1);
    chk("b2b_busy",      busy,    1);
    chk("b2b_prod_held", product, 12'hEF1);
    feed(8'h80, 1'b0, -1, 12'hEF1, stream, nbits, done_cyc, first_v, errs);
    chk("b2b_stream",  stream,   12'h080);
    chk("b2b_done_at", done_cyc, 12);
    chk("b2b_product", product,  12'h080);
    chk("b2b_errs",    errs,     0);
    @(posedge clk); #1;

    // 0xA * 0x03 with x_valid toggling
    start_op(4'hA);
    feed(8'h03, 1'b1, -1, 12'h080, stream, nbits, done_cyc, first_v, errs);
    chk("tog_stream",  stream,   12'h01E);
    chk("tog_nbits",   nbits,    12);
    chk("tog_done_at", done_cyc, 19);
    chk("tog_product", product,  12'h01E);
    chk("tog_errs",    errs,     0);
    @(posedge clk); #1;

    // start pulsed during RUN must be ignored
    start_op(4'h3);
    feed(8'h05, 1'b0, 3, 12'h01E, stream, nbits, done_cyc, first_v, errs);
    chk("ign_stream",  stream,   12'h00F);
    chk("ign_done_at", done_cyc, 12);
    chk("ign_product", product,  12'h00F);
    chk("ign_errs",    errs,     0);
    @(posedge clk); #1;

    // reset after three consumed bits
    start_op(4'h9);
    x_valid = 1'b1; x = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    x_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy",    busy,       0);
    chk("mrst_pvalid",  pbit_valid, 0);
    chk("mrst_product", product,    0);
    chk("mrst_done",    done,       0);
    chk("mrst_xready",  x_ready,    0);
    dn = 0;
    x_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) dn++;
    end
    x_valid = 1'b0;
    chk("mrst_quiet", dn, 0);

    // fresh op after reset: 6 * 7
    start_op(4'h6);
    feed(8'h07, 1'b0, -1, 12'h000, stream, nbits, done_cyc, first_v, errs);
    chk("post_stream",  stream,  12'h02A);
    chk("post_product", product, 12'h02A);
    chk("post_errs",    errs,    0);
    @(posedge clk); #1;

    // y = 0
    start_op(4'h0);
    feed(8'hFF, 1'b0, -1, 12'h02A, stream, nbits, done_cyc, first_v, errs);
    chk("zero_stream",  stream,   12'h000);
    chk("zero_nbits",   nbits,    12);
    chk("zero_done_at", done_cyc, 12);
    chk("zero_product", product,  12'h000);
    chk("zero_errs",    errs,     0);
    @(posedge clk); #1;
    chk("zero_done_width", done,    0);
    chk("zero_prod_held",  product, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
